// File: rtl/flatten_buffer_if.sv
// rtl/flatten_buffer_if.sv - input pixel lanes and output word stream of the flatten stage
interface flatten_buffer_if #(
  parameter int NumberOfK          = 4,
  parameter int ProcessingElements = 2,
  parameter int BitSize            = 32
);
  logic [NumberOfK-1:0]                  in_valid;
  logic [ProcessingElements*BitSize-1:0] in_data;
  logic                                  in_set_done;
  logic                                  in_ready;
  logic                                  out_valid;
  logic [BitSize-1:0]                    out_data;
  logic                                  out_last;
  logic                                  out_ready;

  modport master (
    output in_valid, in_data, in_set_done, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_set_done, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/flatten_buffer.sv
// rtl/flatten_buffer.sv - ping-pong flatten buffer: kernel-major capture, one word per cycle drain
module flatten_buffer #(
  parameter int NumberOfK          = 4,
  parameter int ProcessingElements = 2,
  parameter int BitSize            = 32,
  parameter int OutImageWidth      = 2
) (
  input  logic             clk,
  input  logic             res,
  flatten_buffer_if.slave  bus,
  output logic             overflow,
  output logic             short_set
);
  localparam int PixelsPerK = OutImageWidth * OutImageWidth;
  localparam int Depth      = NumberOfK * PixelsPerK;
  localparam int AddrW      = $clog2(Depth);
  localparam int CntW       = $clog2(PixelsPerK + 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(PixelsPerK);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_DRAINING} bank_t;
  typedef enum logic [1:0] {D_IDLE, D_LOAD, D_STREAM} drain_t;

  logic [BitSize-1:0] mem [2][Depth];
  logic [Depth-1:0]   mask [2];
  bank_t              bank_st [2];
  logic               fill_bank, drain_bank;
  logic [CntW-1:0]    cnt [NumberOfK];
  drain_t             d_state, d_next;
  logic [AddrW-1:0]   rd_addr, rd_sel;
  logic [BitSize-1:0] rd_word;

  logic [NumberOfK-1:0] wr_en, drop;
  logic [AddrW-1:0]     wr_addr [NumberOfK];
  logic [BitSize-1:0]   wr_data [NumberOfK];
  logic                 all_full, any_wr, fill_open, complete;
  logic                 start_drain, advance, release_bank;

  assign fill_open   = (bank_st[fill_bank] == BANK_EMPTY) || (bank_st[fill_bank] == BANK_FILLING);
  assign bus.in_ready = fill_open;

  // all_full looks at the counters as they will be after this edge's writes
  always_comb begin
    wr_en    = '0;
    drop     = '0;
    all_full = 1'b1;
    for (int k = 0; k < NumberOfK; k++) begin
      wr_addr[k] = AddrW'(k * PixelsPerK) + AddrW'(cnt[k]);
      wr_data[k] = bus.in_data[(k % ProcessingElements) * BitSize +: BitSize];
      if (bus.in_valid[k]) begin
        if (fill_open && cnt[k] != CntFull) wr_en[k] = 1'b1;
        else                                drop[k]  = 1'b1;
      end
      if (cnt[k] + CntW'(wr_en[k]) != CntFull) all_full = 1'b0;
    end
    any_wr   = |wr_en;
    complete = fill_open &&
               (all_full || (bus.in_set_done && (bank_st[fill_bank] == BANK_FILLING || any_wr)));
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NumberOfK; k++) begin
      if (!res && wr_en[k]) mem[fill_bank][wr_addr[k]] <= wr_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      mask[0]    <= '0;
      mask[1]    <= '0;
      fill_bank  <= 1'b0;
      drain_bank <= 1'b0;
      overflow   <= 1'b0;
      short_set  <= 1'b0;
      for (int k = 0; k < NumberOfK; k++) cnt[k] <= '0;
    end else begin
      overflow  <= overflow | (|drop);
      short_set <= short_set | (complete && !all_full);
      for (int k = 0; k < NumberOfK; k++) begin
        if (wr_en[k]) mask[fill_bank][wr_addr[k]] <= 1'b1;
        if (complete)      cnt[k] <= '0;
        else if (wr_en[k]) cnt[k] <= cnt[k] + CntW'(1);
      end
      if (any_wr && bank_st[fill_bank] == BANK_EMPTY) bank_st[fill_bank] <= BANK_FILLING;
      if (complete) begin
        bank_st[fill_bank] <= BANK_FULL;
        fill_bank          <= ~fill_bank;
      end
      // the drain bank is never the open fill bank, so these cannot collide with the above
      if (start_drain) bank_st[drain_bank] <= BANK_DRAINING;
      if (release_bank) begin
        bank_st[drain_bank] <= BANK_EMPTY;
        mask[drain_bank]    <= '0;
        drain_bank          <= ~drain_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) d_state <= D_IDLE;
    else     d_state <= d_next;
  end

  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE:   if (bank_st[drain_bank] == BANK_FULL) d_next = D_LOAD;
      D_LOAD:   d_next = D_STREAM;
      D_STREAM: if (release_bank) d_next = D_IDLE;
      default:  d_next = D_IDLE;
    endcase
  end

  always_comb begin
    start_drain   = (d_state == D_IDLE) && (bank_st[drain_bank] == BANK_FULL);
    bus.out_valid = (d_state == D_STREAM);
    bus.out_last  = (d_state == D_STREAM) && (rd_addr == LastAddr);
    advance       = bus.out_valid && bus.out_ready;
    release_bank  = advance && bus.out_last;
  end

  // entries never written for this set read back as zero
  assign rd_sel  = (d_state == D_STREAM) ? rd_addr + AddrW'(1) : rd_addr;
  assign rd_word = mask[drain_bank][rd_sel] ? mem[drain_bank][rd_sel] : '0;

  always_ff @(posedge clk) begin
    if (res) begin
      rd_addr      <= '0;
      bus.out_data <= '0;
    end else if (d_state == D_LOAD) begin
      bus.out_data <= rd_word;
    end else if (advance) begin
      if (bus.out_last) begin
        rd_addr <= '0;
      end else begin
        rd_addr      <= rd_addr + AddrW'(1);
        bus.out_data <= rd_word;
      end
    end
  end
endmodule

// File: tb/tb_flatten_buffer.sv
// tb/tb_flatten_buffer.sv - self-checking bench for flatten_buffer
module tb_flatten_buffer;
  localparam int NK = 4, PE = 2, BW = 32, PIX = 4;

  logic clk = 1'b0;
  logic res;
  logic overflow, short_set;
  always #5 clk = ~clk;

  flatten_buffer_if #(.NumberOfK(NK), .ProcessingElements(PE), .BitSize(BW)) bus();

  flatten_buffer #(.NumberOfK(NK), .ProcessingElements(PE), .BitSize(BW), .OutImageWidth(2)) dut (
    .clk(clk), .res(res), .bus(bus), .overflow(overflow), .short_set(short_set)
  );

  typedef struct packed {logic [31:0] data; logic last;} exp_t;
  typedef struct {
    logic [3:0]  valid;
    logic [31:0] d0, d1;
    logic        done;
    logic        exp_ready;
    logic        exp_ovf;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0, n_errors = 0, n_out = 0;
  bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] val(input int s, input int k, input int p);
    return 32'(s * 256 + 16 * k + p);
  endfunction

  task automatic push_set(input int s);
    for (int k = 0; k < NK; k++)
      for (int p = 0; p < PIX; p++)
        sb.push_back('{data: val(s, k, p), last: (k == NK - 1 && p == PIX - 1)});
  endtask

  task automatic feed_set(input int s);
    push_set(s);
    for (int h = 0; h < 2; h++)
      for (int p = 0; p < PIX; p++) begin
        @(negedge clk);
        bus.in_valid = (h == 0) ? 4'b0011 : 4'b1100;
        bus.in_data  = {val(s, 2 * h + 1, p), val(s, 2 * h, p)};
      end
    @(negedge clk);
    bus.in_valid = '0;
  endtask

  task automatic wait_drain(input bit bp, input int budget);
    int c = 0;
    while ((sb.size() != 0 || bus.out_valid) && c < budget) begin
      @(negedge clk);
      bus.out_ready = bp ? pat[c % 4] : 1'b1;
      c++;
    end
    chk("drain_done", c < budget, 1);
    bus.out_ready = 1'b1;
  endtask

  // output monitor: scoreboard pop on handshake, stability while stalled
  bit          stall = 1'b0;
  logic [31:0] hold_d;
  logic        hold_l;
  exp_t        e;
  always begin
    @(negedge clk);
    #2;
    if (res) begin
      stall = 1'b0;
    end else begin
      if (stall && bus.out_valid) begin
        chk("stall_data", bus.out_data, hold_d);
        chk("stall_last", bus.out_last, hold_l);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_last", bus.out_last, e.last);
        end
        n_out++;
      end
      stall  = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      hold_l = bus.out_last;
    end
  end

  vec_t tbl [8];
  int   base, c;

  initial begin
    res = 1'b1;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.in_set_done = 1'b0;
    bus.out_ready = 1'b1;
    for (int p = 0; p < PIX; p++) begin
      tbl[p]     = '{4'b0011, val(0, 0, p), val(0, 1, p), 1'b0, 1'b1, 1'b0};
      tbl[4 + p] = '{4'b1100, val(0, 2, p), val(0, 3, p), 1'b0, 1'b1, 1'b0};
    end
    repeat (3) @(negedge clk);
    res = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_short_set", short_set, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // basic set, table-driven
    push_set(0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid    = tbl[i].valid;
      bus.in_data     = {tbl[i].d1, tbl[i].d0};
      bus.in_set_done = tbl[i].done;
      chk("tbl_in_ready", bus.in_ready, tbl[i].exp_ready);
      chk("tbl_overflow", overflow, tbl[i].exp_ovf);
    end
    @(negedge clk);
    bus.in_valid = '0;
    chk("lat_idle", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_load", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_first", bus.out_valid, 1);
    wait_drain(1'b0, 100);

    // backpressure
    feed_set(1);
    wait_drain(1'b1, 300);
    chk("bp_overflow", overflow, 0);

    // ping-pong with consumer stalled
    bus.out_ready = 1'b0;
    feed_set(2);
    feed_set(3);
    chk("pp_ready_low", bus.in_ready, 0);
    @(negedge clk);
    bus.in_valid = 4'b0001;
    bus.in_data  = {32'd0, 32'hdead};
    @(negedge clk);
    bus.in_valid = '0;
    chk("pp_overflow", overflow, 1);
    wait_drain(1'b0, 300);
    chk("pp_ready_high", bus.in_ready, 1);

    // set_done on an empty fill bank is ignored
    @(negedge clk);
    bus.in_set_done = 1'b1;
    @(negedge clk);
    bus.in_set_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("empty_done_valid", bus.out_valid, 0);
    chk("empty_done_short", short_set, 0);

    // short set: kernel 0 only, rest reads as zero
    for (int i = 0; i < 16; i++) sb.push_back('{data: (i < 4) ? 32'(5 + i) : 32'd0, last: (i == 15)});
    for (int p = 0; p < PIX; p++) begin
      @(negedge clk);
      bus.in_valid = 4'b0001;
      bus.in_data  = {32'd0, 32'(5 + p)};
    end
    @(negedge clk);
    bus.in_valid    = '0;
    bus.in_set_done = 1'b1;
    @(negedge clk);
    bus.in_set_done = 1'b0;
    chk("short_set", short_set, 1);
    wait_drain(1'b0, 100);

    // reset mid-drain
    base = n_out;
    feed_set(4);
    c = 0;
    while (n_out < base + 7 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("rst_wait", c < 200, 1);
    res = 1'b1;
    sb.delete();
    @(negedge clk);
    res = 1'b0;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_short", short_set, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    repeat (5) @(negedge clk);
    chk("mid_rst_quiet", bus.out_valid, 0);
    feed_set(5);
    wait_drain(1'b0, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
